fare_responder: RTL and testbench

Card/fare-account side of the gate's card interface: the block the gate FSM talks to when a rider taps. It accepts a tap for one of NUM_CARDS cards and looks up that card's active flag and balance. It presents `nfc` / `card_active` / `fund_enough` to the gate, then waits a bounded time for the gate's `reduce_bal` strobe and deducts FARE from the card. A load port tops up balances and sets or clears active flags.

---
 rtl/fare_responder.sv | 167 ++++++++++++++++
 tb/tb_fare_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fare_responder.sv
// fare_responder: card/fare-account side of the gate interface.
// Looks up a tapped card, presents the verdict, deducts FARE on strobe.
module fare_responder #(
    parameter int NUM_CARDS   = 4,
    parameter int BAL_W       = 8,
    parameter int FARE        = 3,
    parameter int INIT_BAL    = 10,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tap_valid,
    input  logic [$clog2(NUM_CARDS)-1:0] tap_id,
    input  logic                         load_valid,
    input  logic [$clog2(NUM_CARDS)-1:0] load_id,
    input  logic [BAL_W-1:0]             load_amt,
    input  logic                         load_active,
    input  logic                         reduce_bal,
    output logic                         nfc,
    output logic                         card_active,
    output logic                         fund_enough,
    output logic                         busy,
    output logic                         deduct_done,
    output logic                         ack_timeout,
    output logic                         tap_drop
);

    localparam int ID_W  = $clog2(NUM_CARDS);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [BAL_W:0]   FARE_X = (BAL_W + 1)'(FARE);
    localparam logic [BAL_W:0]   MAX_X  = {1'b0, {BAL_W{1'b1}}};
    localparam logic [BAL_W-1:0] INIT_V = BAL_W'(INIT_BAL);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        PRESENT,
        WAIT_ACK,
        DEDUCT
    } state_t;

    state_t               state;
    logic [ID_W-1:0]      id;
    logic                 rd_phase;
    logic                 rd_active;
    logic                 rd_enough;
    logic [CNT_W-1:0]     cnt;
    logic [BAL_W-1:0]     bal [NUM_CARDS];
    logic [NUM_CARDS-1:0] active;
    logic [BAL_W:0]       sum [NUM_CARDS];
    logic                 deducting;

    assign busy      = (state != IDLE);
    assign deducting = (state == DEDUCT);

    // Transaction FSM; the card record is read into a register first,
    // then the verdict is registered onto the outputs with nfc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            id          <= '0;
            rd_phase    <= 1'b0;
            rd_active   <= 1'b0;
            rd_enough   <= 1'b0;
            cnt         <= '0;
            nfc         <= 1'b0;
            card_active <= 1'b0;
            fund_enough <= 1'b0;
            deduct_done <= 1'b0;
            ack_timeout <= 1'b0;
            tap_drop    <= 1'b0;
        end else begin
            nfc         <= 1'b0;
            deduct_done <= 1'b0;
            ack_timeout <= 1'b0;
            tap_drop    <= tap_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (tap_valid) begin
                        id       <= tap_id;
                        rd_phase <= 1'b0;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!rd_phase) begin
                        rd_active <= active[id];
                        rd_enough <= ({1'b0, bal[id]} >= FARE_X);
                        rd_phase  <= 1'b1;
                    end else begin
                        card_active <= rd_active;
                        fund_enough <= rd_enough;
                        nfc         <= 1'b1;
                        state       <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (card_active && fund_enough) begin
                        cnt   <= '0;
                        state <= reduce_bal ? DEDUCT : WAIT_ACK;
                    end else begin
                        card_active <= 1'b0;
                        fund_enough <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WAIT_ACK: begin
                    if (reduce_bal) begin
                        state <= DEDUCT;
                    end else if (cnt == LAST_C) begin
                        ack_timeout <= 1'b1;
                        card_active <= 1'b0;
                        fund_enough <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEDUCT: begin
                    deduct_done <= 1'b1;
                    card_active <= 1'b0;
                    fund_enough <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next balance per card: load and deduct combine in BAL_W+1 bits.
    // bal >= FARE was seen at lookup and loads only add, so no underflow.
    always_comb begin
        for (int i = 0; i < NUM_CARDS; i++) begin
            sum[i] = {1'b0, bal[i]};
            if (load_valid && load_id == ID_W'(i)) begin
                sum[i] = sum[i] + {1'b0, load_amt};
            end
            if (deducting && id == ID_W'(i)) begin
                sum[i] = sum[i] - FARE_X;
            end
        end
    end

    // Card records: saturating balance update and active-flag loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                bal[i] <= INIT_V;
            end
            active <= '1;
        end else begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                if (sum[i] > MAX_X) begin
                    bal[i] <= MAX_X[BAL_W-1:0];
                end else begin
                    bal[i] <= sum[i][BAL_W-1:0];
                end
            end
            if (load_valid) begin
                active[load_id] <= load_active;
            end
        end
    end

endmodule

// File: tb/tb_fare_responder.sv
// tb_fare_responder: vector table, hand sequences and randomized
// transactions checked against an arithmetic account model.
module tb_fare_responder;

    localparam int NC    = 4;
    localparam int BW    = 8;
    localparam int FARE  = 3;
    localparam int INIT  = 10;
    localparam int ATO   = 8;
    localparam int MAXB  = (1 << BW) - 1;

    logic          clk;
    logic          rst_n;
    logic          tap_valid;
    logic [1:0]    tap_id;
    logic          load_valid;
    logic [1:0]    load_id;
    logic [BW-1:0] load_amt;
    logic          load_active;
    logic          reduce_bal;
    logic          nfc;
    logic          card_active;
    logic          fund_enough;
    logic          busy;
    logic          deduct_done;
    logic          ack_timeout;
    logic          tap_drop;

    int checks = 0;
    int fails  = 0;
    int m_bal [NC];
    bit m_act [NC];

    fare_responder #(
        .NUM_CARDS(NC), .BAL_W(BW), .FARE(FARE),
        .INIT_BAL(INIT), .ACK_TIMEOUT(ATO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tap_valid(tap_valid), .tap_id(tap_id),
        .load_valid(load_valid), .load_id(load_id),
        .load_amt(load_amt), .load_active(load_active),
        .reduce_bal(reduce_bal),
        .nfc(nfc), .card_active(card_active),
        .fund_enough(fund_enough), .busy(busy),
        .deduct_done(deduct_done), .ack_timeout(ack_timeout),
        .tap_drop(tap_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit pre;
        int pre_amt;
        bit pre_act;
        int mode;
        int j;
        int ld_c;
        int ld_amt;
        int drop_c;
        bit e_act;
        bit e_en;
        int e_bal;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int sat(int x);
        return (x > MAXB) ? MAXB : x;
    endfunction

    task automatic do_load(int id, int amt, bit act);
        load_valid  = 1'b1;
        load_id     = 2'(id);
        load_amt    = BW'(amt);
        load_active = act;
        @(negedge clk);
        load_valid  = 1'b0;
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_nfc"}, nfc, 0);
        chk({tag, "_card_active"}, card_active, 0);
        chk({tag, "_fund_enough"}, fund_enough, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_deduct_done"}, deduct_done, 0);
        chk({tag, "_ack_timeout"}, ack_timeout, 0);
        chk({tag, "_tap_drop"}, tap_drop, 0);
    endtask

    // mode 0: strobe in PRESENT; 1: strobe on j-th WAIT_ACK edge;
    // 2: no strobe. ld_c / drop_c: cycle index after PRESENT (-1 none).
    task automatic run_txn(int id, int mode, int j, int ld_c, int ld_id,
                           int ld_amt, bit ld_act, int drop_c,
                           bit e_act, bit e_en);
        bit appr;
        int cs;
        int e;
        appr = e_act && e_en;
        cs   = (mode == 0) ? 0 : j;
        e    = !appr ? 0 : ((mode == 2) ? ATO : cs + 1);
        tap_valid = 1'b1;
        tap_id    = 2'(id);
        @(negedge clk);
        tap_valid = 1'b0;
        chk("busy_after_tap", busy, 1);
        chk("nfc_early", nfc, 0);
        @(negedge clk);
        chk("nfc_lookup", nfc, 0);
        @(negedge clk);
        chk("nfc_pulse", nfc, 1);
        chk("card_active", card_active, e_act);
        chk("fund_enough", fund_enough, e_en);
        for (int c = 0; c <= e || c <= ld_c; c++) begin
            reduce_bal = (mode != 2) && (c == cs);
            if (c == ld_c) begin
                load_valid  = 1'b1;
                load_id     = 2'(ld_id);
                load_amt    = BW'(ld_amt);
                load_active = ld_act;
            end
            if (c == drop_c) tap_valid = 1'b1;
            @(negedge clk);
            reduce_bal = 1'b0;
            load_valid = 1'b0;
            tap_valid  = 1'b0;
            chk("busy", busy, int'(c < e));
            chk("nfc_low", nfc, 0);
            chk("deduct_done", deduct_done,
                int'(appr && mode != 2 && c == e));
            chk("ack_timeout", ack_timeout,
                int'(appr && mode == 2 && c == e));
            chk("tap_drop", tap_drop, int'(c == drop_c));
            chk("card_active_hold", card_active,
                (c < e) ? int'(e_act) : 0);
            chk("fund_enough_hold", fund_enough,
                (c < e) ? int'(e_en) : 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_bal[i] = INIT;
            m_act[i] = 1'b1;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        tap_valid   = 1'b0;
        tap_id      = '0;
        load_valid  = 1'b0;
        load_id     = '0;
        load_amt    = '0;
        load_active = 1'b0;
        reduce_bal  = 1'b0;

        //        id pre amt act mode j ld_c ldamt drop act en bal
        vecs[0]  = '{0, 0, 0,   0, 0, 0, -1, 0, -1, 1, 1, 7};
        vecs[1]  = '{1, 1, 0,   0, 0, 0, -1, 0, -1, 0, 1, 10};
        vecs[2]  = '{2, 0, 0,   0, 0, 0, -1, 0, -1, 1, 1, 7};
        vecs[3]  = '{2, 0, 0,   0, 1, 1, -1, 0, -1, 1, 1, 4};
        vecs[4]  = '{2, 0, 0,   0, 0, 0, -1, 0,  0, 1, 1, 1};
        vecs[5]  = '{2, 0, 0,   0, 0, 0, -1, 0, -1, 1, 0, 1};
        vecs[6]  = '{3, 0, 0,   0, 2, 0, -1, 0, -1, 1, 1, 10};
        vecs[7]  = '{3, 0, 0,   0, 1, 8, -1, 0, -1, 1, 1, 7};
        vecs[8]  = '{0, 1, 255, 1, 2, 0, -1, 0, -1, 1, 1, 255};
        vecs[9]  = '{0, 0, 0,   0, 0, 0,  1, 5, -1, 1, 1, 255};
        vecs[10] = '{1, 1, 250, 1, 0, 0, -1, 0, -1, 1, 1, 252};

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        for (int i = 0; i < NC; i++) begin
            chk("reset_bal", dut.bal[i], INIT);
            chk("reset_active", dut.active[i], 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].pre) begin
                do_load(vecs[v].id, vecs[v].pre_amt, vecs[v].pre_act);
            end
            run_txn(vecs[v].id, vecs[v].mode, vecs[v].j, vecs[v].ld_c,
                    vecs[v].id, vecs[v].ld_amt, 1'b1, vecs[v].drop_c,
                    vecs[v].e_act, vecs[v].e_en);
            chk($sformatf("vec%0d_bal", v), dut.bal[vecs[v].id],
                vecs[v].e_bal);
        end

        // Reset during WAIT_ACK with a same-edge load on the tapped card.
        tap_valid = 1'b1;
        tap_id    = 2'd3;
        @(negedge clk);
        tap_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seq_nfc", nfc, 1);
        repeat (2) @(negedge clk);
        chk("rst_seq_busy", busy, 1);
        rst_n       = 1'b0;
        load_valid  = 1'b1;
        load_id     = 2'd3;
        load_amt    = 8'd50;
        load_active = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        load_valid = 1'b0;
        check_idle_outputs("midrst");
        for (int i = 0; i < NC; i++) begin
            chk("midrst_bal", dut.bal[i], INIT);
            chk("midrst_active", dut.active[i], 1);
        end
        model_reset();

        for (int n = 0; n < 60; n++) begin
            int  id, mode, j, ld_c, ld_id, ld_amt, drop_c, d, r;
            bit  ld_act, appr;
            id = $urandom_range(0, NC - 1);
            if ($urandom_range(0, 2) == 0) begin
                int  amt;
                bit  act;
                amt = ($urandom_range(0, 4) == 0) ?
                      $urandom_range(0, MAXB) : $urandom_range(0, 8);
                act = ($urandom_range(0, 3) != 0);
                do_load(id, amt, act);
                m_bal[id] = sat(m_bal[id] + amt);
                m_act[id] = act;
            end
            mode   = $urandom_range(0, 2);
            j      = $urandom_range(1, ATO);
            r      = $urandom_range(0, 3);
            ld_c   = (r < 2) ? -1 : r - 2;
            ld_id  = $urandom_range(0, NC - 1);
            ld_amt = ($urandom_range(0, 5) == 0) ?
                     MAXB : $urandom_range(0, 12);
            ld_act = ($urandom_range(0, 4) != 0);
            drop_c = ($urandom_range(0, 1) == 0) ? 0 : -1;
            appr   = m_act[id] && (m_bal[id] >= FARE);
            run_txn(id, mode, j, ld_c, ld_id, ld_amt, ld_act, drop_c,
                    m_act[id], m_bal[id] >= FARE);
            d = (appr && mode != 2) ? ((mode == 0) ? 1 : j + 1) : -1;
            if (ld_c >= 0 && ld_id == id && d >= 0) begin
                if (ld_c < d)
                    m_bal[id] = sat(m_bal[id] + ld_amt) - FARE;
                else
                    m_bal[id] = sat(m_bal[id] - FARE + ld_amt);
            end else begin
                if (d >= 0) m_bal[id] = m_bal[id] - FARE;
                if (ld_c >= 0) m_bal[ld_id] = sat(m_bal[ld_id] + ld_amt);
            end
            if (ld_c >= 0) m_act[ld_id] = ld_act;
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("rnd%0d_bal%0d", n, i), dut.bal[i], m_bal[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
